// File: rtl/fb_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fb_access_sched
//  Description : Frame-buffer port scheduler. Time-shares one single-port
//                BRAM between the VGA scan read (p_tick cycles), pen-pixel
//                draw writes and a full-screen clear sweep (other cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_access_sched #(
    parameter int          HRES       = 160,
    parameter int          VRES       = 120,
    parameter int          SCALE_SH   = 2,
    parameter int          ADDR_W     = 15,
    parameter logic [11:0] RESET_BG   = 12'h000,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        scan_x,
    input  logic [9:0]        scan_y,
    input  logic              draw_valid,
    input  logic [7:0]        draw_x,
    input  logic [6:0]        draw_y,
    input  logic [11:0]       draw_rgb,
    output logic              draw_ready,
    input  logic              clr_req,
    input  logic [11:0]       bg_rgb,
    output logic              clr_busy,
    output logic              fb_en,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_wdata,
    input  logic [11:0]       fb_rdata,
    output logic [11:0]       rgb_out
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t             c_rst_state = CLR_ON_RST ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_W-1:0]  c_hres      = ADDR_W'(HRES);
    localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(HRES * VRES - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [11:0]         r_bg_q;
    logic                r_rd_pend;
    logic                r_von_q;

    logic [ADDR_W-1:0]   w_scan_col;
    logic [ADDR_W-1:0]   w_scan_row;
    logic [ADDR_W-1:0]   w_scan_addr;
    logic                w_draw_in_range;
    logic [ADDR_W-1:0]   w_draw_col;
    logic [ADDR_W-1:0]   w_draw_row;
    logic [ADDR_W-1:0]   w_draw_addr;
    logic                w_xfer;

    // Scan position scaled down to frame-buffer coordinates.
    assign w_scan_col  = ADDR_W'(scan_x >> SCALE_SH);
    assign w_scan_row  = ADDR_W'(scan_y >> SCALE_SH);
    assign w_scan_addr = w_scan_row * c_hres + w_scan_col;

    // Out-of-range draws are zeroed before the multiply so they never alias
    // onto a legal address; they are accepted and dropped.
    assign w_draw_in_range = ({24'd0, draw_x} < 32'(HRES)) && ({25'd0, draw_y} < 32'(VRES));
    assign w_draw_col      = w_draw_in_range ? ADDR_W'(draw_x) : '0;
    assign w_draw_row      = w_draw_in_range ? ADDR_W'(draw_y) : '0;
    assign w_draw_addr     = w_draw_row * c_hres + w_draw_col;

    // Draws are only accepted in IDLE write slots, and never while in reset.
    assign draw_ready = reset_n && (r_state == ST_IDLE) && !p_tick;
    assign w_xfer     = draw_valid && draw_ready;
    assign clr_busy   = (r_state == ST_CLEAR);

    // BRAM port mux: scan read owns p_tick cycles, otherwise clear or draw.
    always_comb begin
        fb_en    = 1'b0;
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        if (reset_n) begin
            if (p_tick) begin
                fb_en   = video_on;
                fb_addr = w_scan_addr;
            end else if (r_state == ST_CLEAR) begin
                fb_en    = 1'b1;
                fb_we    = 1'b1;
                fb_addr  = r_clr_addr;
                fb_wdata = r_bg_q;
            end else if (w_xfer && w_draw_in_range) begin
                fb_en    = 1'b1;
                fb_we    = 1'b1;
                fb_addr  = w_draw_addr;
                fb_wdata = draw_rgb;
            end
        end
    end

    // Clear sequencer: IDLE waits for clr_req, CLEAR sweeps one address per write slot.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_rst_state;
            r_clr_addr <= '0;
            r_bg_q     <= RESET_BG;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                        r_bg_q     <= bg_rgb;
                    end
                end
                ST_CLEAR: begin
                    if (!p_tick) begin
                        if (r_clr_addr == c_last_addr) begin
                            r_state    <= ST_IDLE;
                            r_clr_addr <= '0;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_clr_addr <= '0;
                end
            endcase
        end
    end

    // Read pipeline: capture video_on with the read slot, load the pixel once
    // the BRAM data arrives one cycle later.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_von_q   <= 1'b0;
            rgb_out   <= 12'h000;
        end else begin
            r_rd_pend <= p_tick;
            if (p_tick) begin
                r_von_q <= video_on;
            end
            if (r_rd_pend) begin
                rgb_out <= r_von_q ? fb_rdata : 12'h000;
            end
        end
    end

endmodule
`default_nettype wire
